// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port and transmitter handshake bundled for the UART transmit feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
    logic                   overflow;
    logic                   ovf_clear;
    logic                   tx_baud;
    logic                   tx_done;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   busy;

    modport master (
        output wr_en, wr_data, ovf_clear, tx_baud, tx_done,
        input  full, empty, count, overflow, tx_start, tx_data, busy
    );

    modport slave (
        input  wr_en, wr_data, ovf_clear, tx_baud, tx_done,
        output full, empty, count, overflow, tx_start, tx_data, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO; flags are decoded from the registered occupancy count.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   wr_ok;
    logic                   rd_ok;

    // Qualify against registered flags so a full FIFO drops writes even when a pop lands the same cycle.
    assign wr_ok   = push && !full;
    assign rd_ok   = pop && !empty;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and presents them one at a time to the UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_tx_feeder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t                 state;
    state_t                 state_nxt;
    logic                   pop;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic [UART_DATA_W-1:0] tx_data_r;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            fifo_count;
    logic                   overflow_r;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes outside their own state are ignored: tx_done only matters in S_WAIT, tx_baud only in S_REQ.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.tx_baud) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_data_r <= '0;
        end else if (pop) begin
            tx_data_r <= fifo_rd_data;
        end
    end

    // A dropped write in the same cycle as ovf_clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            overflow_r <= 1'b1;
        end else if (bus.ovf_clear) begin
            overflow_r <= 1'b0;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_r;
    assign bus.tx_start = (state == S_REQ);
    assign bus.tx_data  = tx_data_r;
    assign bus.busy     = (state != S_IDLE);

endmodule
